bb_seq_mac: RTL and testbench

Time-multiplexed multiply-accumulate sequencer for the BC-MAC datapath. It decomposes one 2-bit or 4-bit operand pair into 2-bit bit-brick partial products and issues them to a single internal brick multiplier, one per cycle. Each partial product is shifted and accumulated into a running accumulator, which is returned through a valid/ready handshake. It sits between the operand feeder and the result writeback, so precision-scalable MACs run on one brick instead of four.

---
 rtl/bb_seq_mac_if.sv | 23 ++
 rtl/bb_seq_mac.sv | 70 +++++++
 tb/tb_bb_seq_mac.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/bb_seq_mac_if.sv
// bb_seq_mac_if: operand/result handshake bundle; master = feeder+writeback side, slave = bb_seq_mac
interface bb_seq_mac_if #(parameter int ACC_W = 16);
  logic in_valid;
  logic in_ready;
  logic mode;
  logic x_sign;
  logic y_sign;
  logic [3:0] x;
  logic [3:0] y;
  logic acc_clr;
  logic out_valid;
  logic out_ready;
  logic [ACC_W-1:0] acc;
  logic busy;
  modport master (
    output in_valid, mode, x_sign, y_sign, x, y, acc_clr, out_ready,
    input in_ready, out_valid, acc, busy
  );
  modport slave (
    input in_valid, mode, x_sign, y_sign, x, y, acc_clr, out_ready,
    output in_ready, out_valid, acc, busy
  );
endinterface

// File: rtl/bb_seq_mac.sv
// bb_seq_mac: 2/4-bit MAC on one 2-bit brick multiplier; ports clk, rst (async high), bus (operands in, acc out, valid/ready both ways, busy)
module bb_seq_mac #(
  parameter int ACC_W = 16
) (
  input logic clk,
  input logic rst,
  bb_seq_mac_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, nxt;
  logic [1:0] step;
  logic m, xs, ys;
  logic [3:0] xr, yr;
  logic [ACC_W-1:0] acc;
  logic [1:0] a, b, sft;
  logic a_top, b_top, last, take;
  logic signed [2:0] ae, be;
  logic signed [5:0] pp;
  logic [3:0] shamt;
  logic [ACC_W-1:0] pp_sh;
  always_comb begin
    a = (m & step[1]) ? xr[3:2] : xr[1:0];
    b = (m & step[0]) ? yr[3:2] : yr[1:0];
    a_top = ~m | step[1];
    b_top = ~m | step[0];
    sft = m ? {&step, ^step} : 2'b00;
    ae = {a_top & xs & a[1], a};
    be = {b_top & ys & b[1], b};
    pp = ae * be;
    shamt = (sft == 2'b11) ? 4'd8 : {1'b0, sft, 1'b0};
    pp_sh = {{(ACC_W-6){pp[5]}}, pp} << shamt;
    last = ~m | (&step);
    take = bus.in_valid & (state == IDLE);
    nxt = state;
    case (state)
      IDLE: nxt = take ? RUN : IDLE;
      RUN: nxt = last ? DONE : RUN;
      DONE: nxt = bus.out_ready ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      step <= 2'd0;
      acc <= '0;
      m <= 1'b0;
      xs <= 1'b0;
      ys <= 1'b0;
      xr <= 4'd0;
      yr <= 4'd0;
    end else if (take) begin
      step <= 2'd0;
      m <= bus.mode;
      xs <= bus.x_sign;
      ys <= bus.y_sign;
      xr <= bus.x;
      yr <= bus.y;
      if (bus.acc_clr) acc <= '0;
    end else if (state == RUN) begin
      acc <= acc + pp_sh;
      step <= step + 2'd1;
    end
  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.busy = state != IDLE;
  assign bus.acc = acc;
endmodule

// File: tb/tb_bb_seq_mac.sv
// tb_bb_seq_mac: drives 16-bit and 8-bit accumulator instances in lockstep, scoreboard-checks results
module tb_bb_seq_mac;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic mode = 1'b0;
  logic x_sign = 1'b0;
  logic y_sign = 1'b0;
  logic [3:0] x = 4'd0;
  logic [3:0] y = 4'd0;
  logic acc_clr = 1'b0;
  logic out_ready = 1'b1;
  int checks = 0;
  int errs = 0;
  logic [15:0] q16[$];
  logic [7:0] q8[$];
  always #5 clk = ~clk;
  bb_seq_mac_if #(.ACC_W(16)) b16 ();
  bb_seq_mac_if #(.ACC_W(8)) b8 ();
  assign b16.in_valid = in_valid;
  assign b16.mode = mode;
  assign b16.x_sign = x_sign;
  assign b16.y_sign = y_sign;
  assign b16.x = x;
  assign b16.y = y;
  assign b16.acc_clr = acc_clr;
  assign b16.out_ready = out_ready;
  assign b8.in_valid = in_valid;
  assign b8.mode = mode;
  assign b8.x_sign = x_sign;
  assign b8.y_sign = y_sign;
  assign b8.x = x;
  assign b8.y = y;
  assign b8.acc_clr = acc_clr;
  assign b8.out_ready = out_ready;
  bb_seq_mac #(.ACC_W(16)) dut16 (.clk(clk), .rst(rst), .bus(b16));
  bb_seq_mac #(.ACC_W(8)) dut8 (.clk(clk), .rst(rst), .bus(b8));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  always @(negedge clk)
    if (!rst && b16.out_valid && b16.out_ready) begin
      if (q16.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL acc16: got %0h with no result expected", b16.acc);
      end else chk("acc16", b16.acc, q16.pop_front());
    end
  always @(negedge clk)
    if (!rst && b8.out_valid && b8.out_ready) begin
      if (q8.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL acc8: got %0h with no result expected", b8.acc);
      end else chk("acc8", b8.acc, q8.pop_front());
    end
  task automatic run_op(input logic md, input logic sx, input logic sy, input logic [3:0] xv,
                        input logic [3:0] yv, input logic clr, input logic [15:0] exp,
                        input int lat, input bit chk_mid, input logic [63:0] mid);
    int n;
    n = 0;
    while (!b16.in_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("ready_before_accept", b16.in_ready, 1);
    mode = md;
    x_sign = sx;
    y_sign = sy;
    x = xv;
    y = yv;
    acc_clr = clr;
    in_valid = 1'b1;
    q16.push_back(exp);
    q8.push_back(exp[7:0]);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    x = 4'hx;
    y = 4'hx;
    n = 1;
    while (!b16.out_valid && n < 20) begin
      if (chk_mid && n >= 2) chk($sformatf("mid_step%0d", n - 2), b16.acc, mid[16*(n-2) +: 16]);
      @(posedge clk);
      #1;
      n++;
    end
    if (chk_mid) chk("mid_step3", b16.acc, mid[48 +: 16]);
    chk("latency", n, lat);
    chk("busy_in_done", b16.busy, 1);
    if (out_ready) begin
      @(posedge clk);
      #1;
      chk("handoff_in_ready", b16.in_ready, 1);
      chk("handoff_out_valid", b16.out_valid, 0);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1);
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", b16.in_ready, 1);
    chk("rst_out_valid", b16.out_valid, 0);
    chk("rst_acc", b16.acc, 0);
    chk("rst_busy", b16.busy, 0);
    chk("rst_acc8", b8.acc, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_op(1, 1, 1, 4'b1000, 4'b1000, 1, 16'h0040, 5, 1, {16'd64, 16'd0, 16'd0, 16'd0});
    run_op(1, 0, 0, 4'd15, 4'd15, 1, 16'd225, 5, 0, 64'd0);
    run_op(1, 0, 0, 4'd15, 4'd15, 0, 16'd450, 5, 0, 64'd0);
    run_op(0, 1, 0, 4'b1110, 4'b1101, 1, 16'hFFFE, 2, 0, 64'd0);
    run_op(1, 1, 0, 4'b1001, 4'b0011, 1, 16'hFFEB, 5, 0, 64'd0);
    run_op(0, 1, 1, 4'b0011, 4'b0011, 0, 16'hFFEC, 2, 0, 64'd0);
    out_ready = 1'b0;
    run_op(1, 0, 0, 4'd2, 4'd3, 1, 16'd6, 5, 0, 64'd0);
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      #1;
      chk("bp_acc", b16.acc, 6);
      chk("bp_out_valid", b16.out_valid, 1);
      chk("bp_in_ready", b16.in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp_release_in_ready", b16.in_ready, 1);
    chk("bp_release_out_valid", b16.out_valid, 0);
    chk("bp_release_busy", b16.busy, 0);
    out_ready = 1'b1;
    mode = 1'b1;
    x_sign = 1'b0;
    y_sign = 1'b0;
    x = 4'd15;
    y = 4'd15;
    acc_clr = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_in_ready", b16.in_ready, 1);
    chk("abort_out_valid", b16.out_valid, 0);
    chk("abort_acc", b16.acc, 0);
    chk("abort_busy", b16.busy, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_op(1, 0, 0, 4'd3, 4'd3, 0, 16'd9, 5, 0, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("q16_drained", q16.size(), 0);
    chk("q8_drained", q8.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
